// File: rtl/seg_scan_pkg.sv
// Shared definitions for the seven-segment scanner: widths, off-levels and FSM encoding.
package seg_scan_pkg;

  localparam int unsigned SEG_W = 7;
  localparam int unsigned AN_W  = 8;
  localparam int unsigned IDX_W = 3;

  localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;
  localparam logic [AN_W-1:0]  AN_OFF  = 8'hFF;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Window timer for the scanner: loadable down-counter with a done pulse on its last cycle.
module scan_timer #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned RST_VAL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_done_c
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= CNT_W'(RST_VAL);
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // A window loaded with N ends on the cycle the count reads 1, giving exactly N cycles.
  assign o_done_c = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/seg_scan.sv
// Multiplexed seven-segment scanner: pattern buffer, BLANK/SHOW sequencer and registered drive.
module seg_scan
  import seg_scan_pkg::*;
#(
  parameter int unsigned DIGITS = 8,
  parameter int unsigned DWELL  = 50000,
  parameter int unsigned BLANK  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [SEG_W-1:0] wr_seg,
  output logic [SEG_W-1:0] seg_out,
  output logic [AN_W-1:0]  an,
  output logic [IDX_W-1:0] digit_idx
);

  localparam int unsigned      CNT_W    = $clog2(max_u(DWELL, BLANK) + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  scan_state_e      r_state;
  scan_state_e      w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_nxt;
  logic [SEG_W-1:0] r_buf [DIGITS];
  logic [SEG_W-1:0] w_pat;
  logic [SEG_W-1:0] r_seg;
  logic [SEG_W-1:0] w_seg_nxt;
  logic [AN_W-1:0]  r_an;
  logic [AN_W-1:0]  w_an_nxt;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic             w_done;

  scan_timer #(
    .CNT_W  (CNT_W),
    .RST_VAL(BLANK)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst),
    .i_load    (w_load),
    .i_load_val(w_load_val),
    .o_done_c  (w_done)
  );

  // Addresses at or beyond DIGITS match no entry and are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DIGITS); i++) begin
        r_buf[i] <= '0;
      end
    end else if (wr_en) begin
      for (int i = 0; i < int'(DIGITS); i++) begin
        if (wr_addr == IDX_W'(i)) begin
          r_buf[i] <= wr_seg;
        end
      end
    end
  end

  // Current digit's pattern, bypassing a same-cycle write so a live update shows one cycle later.
  always_comb begin
    w_pat = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_pat = r_buf[i];
      end
    end
    if (wr_en && (wr_addr == r_idx)) begin
      w_pat = wr_seg;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_BLANK;
      r_idx   <= '0;
      r_an    <= AN_OFF;
      r_seg   <= SEG_OFF;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_an    <= w_an_nxt;
      r_seg   <= w_seg_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_load      = 1'b0;
    w_load_val  = CNT_W'(BLANK);
    w_an_nxt    = AN_OFF;
    w_seg_nxt   = SEG_OFF;
    if (!en) begin
      // Disabled: park in a fresh BLANK window on the held digit.
      w_state_nxt = ST_BLANK;
      w_load      = 1'b1;
    end else begin
      case (r_state)
        ST_BLANK: begin
          if (w_done) begin
            w_state_nxt = ST_SHOW;
            w_load      = 1'b1;
            w_load_val  = CNT_W'(DWELL);
          end
        end
        ST_SHOW: begin
          w_an_nxt  = ~(AN_W'(1) << r_idx);
          w_seg_nxt = ~w_pat;
          if (w_done) begin
            w_state_nxt = ST_BLANK;
            w_load      = 1'b1;
            w_idx_nxt   = (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
          end
        end
        default: begin
          w_state_nxt = ST_BLANK;
        end
      endcase
    end
  end

  assign seg_out   = r_seg;
  assign an        = r_an;
  assign digit_idx = r_idx;

endmodule
